// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field widths, integer limits and operand classification.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam logic [31:0] INT_MAX  = 32'h7FFFFFFF;
  localparam logic [31:0] INT_MIN  = 32'h80000000;
  localparam logic [31:0] UINT_MAX = 32'hFFFFFFFF;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fp_class_t;

  // zero covers both true zero and subnormals (exponent field all zero)
  function automatic fp_class_t fp_classify(input logic [EXP_W-1:0] exp_f,
                                            input logic [FRAC_W-1:0] frac_f);
    fp_class_t c;
    c.nan  = (exp_f == EXP_MAX) && (frac_f != '0);
    c.inf  = (exp_f == EXP_MAX) && (frac_f == '0);
    c.zero = (exp_f == '0);
    return c;
  endfunction

endpackage

// File: rtl/fp_cvt_align.sv
// Aligns the 24-bit significand to an integer magnitude for unbiased exponent e,
// reporting the bits shifted out (sticky) and magnitudes that do not fit 32 bits.
module fp_cvt_align (
  input  logic [23:0]       mant,
  input  logic signed [8:0] e,
  output logic [31:0]       mag,
  output logic              sticky,
  output logic              ovf
);

  logic [4:0]  rsh;
  logic [5:0]  lsh;
  logic [55:0] wide;

  always_comb begin
    mag    = '0;
    sticky = 1'b0;
    ovf    = 1'b0;
    rsh    = '0;
    lsh    = '0;
    wide   = '0;
    if (e < 9'sd0) begin
      sticky = |mant;
    end else if (e <= 9'sd23) begin
      rsh    = 5'(9'sd23 - e);
      mag    = 32'(mant >> rsh);
      sticky = |(mant & ~(24'hFFFFFF << rsh));
    end else if (e > 9'sd55) begin
      ovf = 1'b1;
    end else begin
      // left shift into a wide intermediate so overflow is visible above bit 31
      lsh  = 6'(e - 9'sd23);
      wide = {32'd0, mant} << lsh;
      mag  = wide[31:0];
      ovf  = |wide[55:32];
    end
  end

endmodule

// File: rtl/fp_to_int_cvt.sv
// Two-stage FP32 -> int32/uint32 converter (round toward zero) with NV/NX flags
// and a valid/ready handshake on both sides.
module fp_to_int_cvt
  import fp_pkg::*;
#(
  parameter bit FTZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_fp,
  input  logic        in_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic        out_nv,
  output logic        out_nx
);

  function automatic logic [31:0] sat_val(input logic neg, input logic uns);
    if (uns) return neg ? 32'd0 : UINT_MAX;
    else     return neg ? INT_MIN : INT_MAX;
  endfunction

  function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] mag);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

  logic vld_p1, vld_p2, adv_p1, adv_p2;

  assign adv_p2   = ~vld_p2 | out_ready;
  assign adv_p1   = ~vld_p1 | adv_p2;
  assign in_ready = adv_p1;

  // ---- stage 1: decode ----
  logic                    sign_p1, uns_p1;
  logic [23:0]             mant_p1;
  fp_class_t               cls_p1;
  logic signed [8:0]       e_p1;

  always_ff @(posedge clk) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (adv_p1) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv_p1 && in_valid) begin
      sign_p1 <= in_fp[31];
      uns_p1  <= in_unsigned;
      mant_p1 <= {in_fp[30:23] != '0, in_fp[22:0]};
      cls_p1  <= fp_classify(in_fp[30:23], in_fp[22:0]);
      e_p1    <= $signed({1'b0, in_fp[30:23]}) - 9'sd127;
    end
  end

  // ---- stage 2: convert ----
  logic [31:0] mag, res;
  logic        sticky, ovf, nv, nx;

  fp_cvt_align u_align (
    .mant   (mant_p1),
    .e      (e_p1),
    .mag    (mag),
    .sticky (sticky),
    .ovf    (ovf)
  );

  always_comb begin
    res = '0;
    nv  = 1'b0;
    nx  = 1'b0;
    if (cls_p1.nan) begin
      res = uns_p1 ? UINT_MAX : INT_MAX;
      nv  = 1'b1;
    end else if (cls_p1.inf) begin
      res = sat_val(sign_p1, uns_p1);
      nv  = 1'b1;
    end else if (cls_p1.zero) begin
      nx = !FTZ && (mant_p1[22:0] != '0);
    end else if (e_p1 < 9'sd0) begin
      nx = 1'b1;
    end else if (uns_p1) begin
      if (sign_p1) begin
        nv = 1'b1;
      end else if (ovf) begin
        res = UINT_MAX;
        nv  = 1'b1;
      end else begin
        res = mag;
        nx  = sticky;
      end
    end else if (e_p1 >= 9'sd31) begin
      // -2^31 is the one representable value at this exponent
      if (sign_p1 && e_p1 == 9'sd31 && mant_p1[22:0] == '0) begin
        res = INT_MIN;
      end else begin
        res = sat_val(sign_p1, 1'b0);
        nv  = 1'b1;
      end
    end else begin
      res = apply_sign(sign_p1, mag);
      nx  = sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      out_int <= '0;
      out_nv  <= 1'b0;
      out_nx  <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        out_int <= res;
        out_nv  <= nv;
        out_nx  <= nx;
      end
    end
  end

  assign out_valid = vld_p2;

endmodule

// File: tb/tb_fp_to_int_cvt.sv
// Directed plus randomized checks of fp_to_int_cvt against a real-arithmetic reference.
module tb_fp_to_int_cvt;

  localparam bit FTZ = 1'b1;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_unsigned, out_valid, out_ready;
  logic [31:0] in_fp, out_int;
  logic        out_nv, out_nx;

  fp_to_int_cvt #(.FTZ(FTZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fp      (in_fp),
    .in_unsigned(in_unsigned),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_int    (out_int),
    .out_nv     (out_nv),
    .out_nx     (out_nx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] v;
    logic        nv;
    logic        nx;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic        held_v = 1'b0;
  logic [31:0] held_int;
  logic        held_nv, held_nx;

  function automatic real pow2(input int n);
    real p = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
    else        for (int i = 0; i < -n; i++) p = p / 2.0;
    return p;
  endfunction

  // value-level model: decode to a real, truncate, then apply range limits
  function automatic exp_t ref_cvt(input logic [31:0] x, input bit u);
    exp_t   r;
    logic   s = x[31];
    int     ex = int'(x[30:23]);
    real    f, t;
    r.x = x; r.v = 32'd0; r.nv = 1'b0; r.nx = 1'b0;
    if (ex == 255) begin
      r.nv = 1'b1;
      if (x[22:0] != 0) r.v = u ? 32'hFFFFFFFF : 32'h7FFFFFFF;
      else if (u)       r.v = s ? 32'd0 : 32'hFFFFFFFF;
      else              r.v = s ? 32'h80000000 : 32'h7FFFFFFF;
      return r;
    end
    if (ex == 0) begin
      r.nx = !FTZ && (x[22:0] != 0);
      return r;
    end
    f = real'({1'b1, x[22:0]}) * pow2(ex - 150);
    if (s) f = -f;
    t = (f < 0.0) ? -$floor(-f) : $floor(f);
    if (u) begin
      if (t <= -1.0)               begin r.nv = 1'b1; return r; end
      if (f >= 4294967296.0)       begin r.v = 32'hFFFFFFFF; r.nv = 1'b1; return r; end
    end else begin
      if (f >= 2147483648.0)       begin r.v = 32'h7FFFFFFF; r.nv = 1'b1; return r; end
      if (f < -2147483648.0)       begin r.v = 32'h80000000; r.nv = 1'b1; return r; end
    end
    r.v  = 32'(longint'(t));
    r.nx = (t != f);
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        n_cmp++;
        assert ({out_valid, out_int, out_nv, out_nx} === {1'b1, held_int, held_nv, held_nx})
        else begin
          n_err++;
          $error("FAIL stall_hold observed v=%0b int=%h nv=%0b nx=%0b required v=1 int=%h nv=%0b nx=%0b",
                 out_valid, out_int, out_nv, out_nx, held_int, held_nv, held_nx);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        assert (q.size() != 0)
        else begin
          n_err++;
          $error("FAIL spurious_out observed int=%h required no output", out_int);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          assert ({out_int, out_nv, out_nx} === {e.v, e.nv, e.nx})
          else begin
            n_err++;
            $error("FAIL cvt x=%h observed int=%h nv=%0b nx=%0b required int=%h nv=%0b nx=%0b",
                   e.x, out_int, out_nv, out_nx, e.v, e.nv, e.nx);
          end
        end
      end
      held_v   = out_valid && !out_ready;
      held_int = out_int;
      held_nv  = out_nv;
      held_nx  = out_nx;
    end
  end

  task automatic send(input logic [31:0] x, input bit u, input exp_t e);
    int guard = 0;
    @(negedge clk);
    in_fp = x; in_unsigned = u; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $error("FAIL accept_timeout x=%h observed in_ready=0 required 1", x);
    end else begin
      q.push_back(e);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_dir(input logic [31:0] x, input bit u, input logic [31:0] v,
                          input logic nv, input logic nx);
    exp_t e;
    e.x = x; e.v = v; e.nv = nv; e.nx = nx;
    send(x, u, e);
  endtask

  task automatic send_rnd(input logic [31:0] x, input bit u);
    send(x, u, ref_cvt(x, u));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    assert (q.size() == 0)
    else begin
      n_err++;
      $error("FAIL drain observed pending=%0d required 0", q.size());
    end
    q.delete();
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic req);
    n_cmp++;
    assert (obs === req)
    else begin
      n_err++;
      $error("FAIL %s observed %0b required %0b", tag, obs, req);
    end
  endtask

  bit rnd_done;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_fp = '0; in_unsigned = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_out_valid", out_valid, 1'b0);
    n_cmp++;
    assert ({out_int, out_nv, out_nx} === 34'd0)
    else begin
      n_err++;
      $error("FAIL rst_outputs observed int=%h nv=%0b nx=%0b required 0", out_int, out_nv, out_nx);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_bit("in_ready_after_rst", in_ready, 1'b1);

    // directed values
    send_dir(32'h3FC00000, 1'b0, 32'h00000001, 1'b0, 1'b1);
    send_dir(32'hC0300000, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1);
    send_dir(32'h4F000000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    send_dir(32'h4F000000, 1'b1, 32'h80000000, 1'b0, 1'b0);
    send_dir(32'hCF000000, 1'b0, 32'h80000000, 1'b0, 1'b0);
    send_dir(32'h7FC00000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    send_dir(32'h7FC00000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    send_dir(32'hFF800000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    send_dir(32'hFF800000, 1'b0, 32'h80000000, 1'b1, 1'b0);
    send_dir(32'h7F800000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    send_dir(32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0);
    send_dir(32'hBF000000, 1'b1, 32'h00000000, 1'b0, 1'b1);
    send_dir(32'hBF800000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    send_dir(32'h3F800000, 1'b1, 32'h00000001, 1'b0, 1'b0);
    send_dir(32'h4F800000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    send_dir(32'h4EFFFFFF, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0);
    send_dir(32'hCF000001, 1'b0, 32'h80000000, 1'b1, 1'b0);
    send_dir(32'h4B7FFFFF, 1'b0, 32'h00FFFFFF, 1'b0, 1'b0);
    drain(20);

    // backpressure: 1.0, 2.0, 3.0, 4.0 with out_ready low for five cycles
    @(posedge clk); #1 out_ready = 1'b0;
    fork
      begin
        send_dir(32'h3F800000, 1'b0, 32'd1, 1'b0, 1'b0);
        send_dir(32'h40000000, 1'b0, 32'd2, 1'b0, 1'b0);
        send_dir(32'h40400000, 1'b0, 32'd3, 1'b0, 1'b0);
        send_dir(32'h40800000, 1'b0, 32'd4, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("bp_in_ready_low", in_ready, 1'b0);
        check_bit("bp_out_valid", out_valid, 1'b1);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain(20);

    // reset with two items in flight
    @(posedge clk); #1 out_ready = 1'b0;
    send_dir(32'h41000000, 1'b0, 32'd8, 1'b0, 1'b0);
    send_dir(32'h40E00000, 1'b0, 32'd7, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b1; q.delete();
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_bit("rst_mid_out_valid", out_valid, 1'b0);
    check_bit("rst_mid_nv", out_nv, 1'b0);
    check_bit("rst_mid_nx", out_nx, 1'b0);
    check_bit("rst_mid_in_ready", in_ready, 1'b1);
    send_dir(32'h41200000, 1'b0, 32'd10, 1'b0, 1'b0);
    drain(4);
    repeat (3) @(negedge clk);
    check_bit("rst_no_stale", out_valid, 1'b0);

    // randomized traffic with random consumer stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [31:0] x;
          x = $urandom;
          if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(115, 162));
          send_rnd(x, 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_to_int_cvt.md
Name: fp_to_int_cvt

Overview:
- Two-stage pipelined converter from IEEE-754 single precision to 32-bit signed or unsigned integer (RISC-V FCVT.W.S / FCVT.WU.S).
- Rounding is fixed to round-toward-zero, matching the truncating FP adder datapath.
- Inverse direction of the adder's integer-to-float normalisation path; sits in the FP execute unit behind a valid/ready handshake.
- Reports the invalid (NV) and inexact (NX) exception flags.

Parameters:
- FTZ, 1: subnormal input treated as ±0, result 0, nx=0. When 0: subnormal gives result 0 with nx=1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- in_fp  in  32  single-precision operand
- in_unsigned  in  1  0 = FCVT.W.S, 1 = FCVT.WU.S
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_int  out  32  integer result
- out_nv  out  1  invalid-operation flag
- out_nx  out  1  inexact flag

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
  - On rst: s1_valid=0, s2_valid=0, out_valid=0, out_int=0, out_nv=0, out_nx=0.
  - rst mid-operation discards all in-flight items; no partial output.
  - in_ready is combinational and reads 1 in the cycle after rst falls.
- Handshake: transfer occurs on valid&&ready at the clock edge.
  - While out_valid=1 and out_ready=0, out_int/out_nv/out_nx are held stable.
- Pipeline:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv.
  - Throughput is 1 per cycle. Latency is 2 cycles, accept edge to out_valid.
  - Up to 2 items are buffered. Order is preserved.
- Stage 1 (decode), registered:
  - sign, exp, mant24 = {exp!=0, frac}, in_unsigned.
  - Class flags: is_nan (exp=FF, frac!=0), is_inf, is_zero_or_sub.
  - E = exp - 127, signed 9-bit.
- Stage 2 (convert), registered:
  - NaN: signed gives 0x7FFFFFFF; unsigned gives 0xFFFFFFFF; nv=1.
  - ±Inf: saturate toward the sign (signed: 0x7FFFFFFF / 0x80000000; unsigned: 0xFFFFFFFF / 0), nv=1.
  - exp=0: result 0, nv=0, nx per FTZ.
  - E<0 (|x|<1): magnitude 0, nx=1, nv=0. This applies to both modes, including negative unsigned.
  - 0<=E<=23: magnitude = mant24 >> (23-E). nx = OR of the dropped bits.
  - E>23: magnitude = mant24 << (E-23), computed in a 56-bit intermediate. nx=0.
  - Signed overflow: E>=31, except x = -2^31 exactly (sign=1, E=31, frac=0), which gives 0x80000000 with nv=0. Overflow saturates as for Inf, nv=1, nx=0.
  - Signed in range: result = sign ? -magnitude : magnitude (two's complement, 32-bit).
  - Unsigned overflow: E>=32, positive, gives 0xFFFFFFFF, nv=1.
  - Unsigned negative with magnitude>=1: result 0, nv=1, nx=0.
  - Flags are exclusive: nv=1 forces nx=0.

Decomposition:
- Package fp_pkg:
  - EXP_W=8, FRAC_W=23, BIAS=127, EXP_MAX=8'hFF.
  - INT_MAX=32'h7FFFFFFF, INT_MIN=32'h80000000, UINT_MAX=32'hFFFFFFFF.
  - fp_class_t struct {nan, inf, zero}.
- Sub-module fp_cvt_align (combinational): takes mant24 and E; returns the 32-bit magnitude, sticky (dropped bits), and overflow. Stage 2 instantiates it.

Test Plan:
1. Signed truncation, both directions:
   - 0x3FC00000 (1.5), signed -> out_int=1, nx=1, nv=0.
   - 0xC0300000 (-2.75), signed -> 0xFFFFFFFE, nx=1.
2. Signed limits:
   - 0x4F000000 (2^31) signed -> 0x7FFFFFFF, nv=1.
   - 0x4F000000 unsigned -> 0x80000000, nv=0, nx=0.
   - 0xCF000000 signed -> 0x80000000, nv=0.
3. Specials:
   - 0x7FC00000 signed -> 0x7FFFFFFF, nv=1; same input unsigned -> 0xFFFFFFFF, nv=1.
   - 0xFF800000 unsigned -> 0, nv=1.
   - 0x00000001 with FTZ=1 -> 0, nx=0.
4. Unsigned negatives:
   - 0xBF000000 (-0.5) -> 0, nx=1, nv=0.
   - 0xBF800000 (-1.0) -> 0, nv=1.
   - 0x3F800000 (1.0) -> 1, no flags.
5. Backpressure:
   - Stimulus: 4 back-to-back inputs (1.0, 2.0, 3.0, 4.0, signed); out_ready=0 for cycles 0-4, then 1.
   - in_ready drops after 2 items are held. Outputs stay stable while stalled. Results appear 1, 2, 3, 4 in order, none lost or duplicated.
6. Reset mid-operation:
   - Stimulus: rst asserted for 1 cycle with 2 items in flight.
   - Next cycle: out_valid=0, flags 0. No stale result emerges. A new input 0x41200000 yields 10 two cycles after acceptance.
